// File: rtl/nn_argmax_stage_pkg.sv
// rtl/nn_argmax_stage_pkg.sv - shared data type and FSM state encoding for the argmax stage
package nn_argmax_stage_pkg;

   localparam int NN_DATA_W = 16;

   // Q8.8 signed score
   typedef logic signed [NN_DATA_W-1:0] nn_data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } nn_argmax_state_t;

endpackage

// File: rtl/nn_argmax_stage.sv
// rtl/nn_argmax_stage.sv - sequential signed argmax over one captured score vector
module nn_argmax_stage
   import nn_argmax_stage_pkg::*;
#(
   parameter int FEATURES = 11,
   parameter int IDX_W    = (FEATURES > 1) ? $clog2(FEATURES) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  nn_data_t         data_i [FEATURES],
   input  logic             data_v,
   output logic             in_ready,
   output logic [IDX_W-1:0] class_o,
   output nn_data_t         max_o,
   output logic             out_v,
   input  logic             out_ready
);

   // cnt carries one extra bit so a power-of-two vector length never wraps it
   localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(FEATURES - 1);

   nn_argmax_state_t state;
   nn_argmax_state_t state_next;

   nn_data_t         vec_buf [FEATURES];
   nn_data_t         best;
   logic [IDX_W-1:0] best_idx;
   logic [IDX_W:0]   cnt;
   logic             take;

   assign take    = (state == IDLE) && data_v;
   assign class_o = best_idx;
   assign max_o   = best;

   // next-state and handshake decode
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_v      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (data_v) begin
               state_next = (FEATURES == 1) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (cnt == LAST_CNT) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_v = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // vector capture; only written in IDLE so later input changes are invisible
   always_ff @(posedge clk) begin
      if (take) begin
         vec_buf <= data_i;
      end
   end

   // running maximum; strict compare keeps the lowest index on ties
   always_ff @(posedge clk) begin
      if (rst) begin
         best     <= '0;
         best_idx <= '0;
         cnt      <= '0;
      end else if (take) begin
         best     <= data_i[0];
         best_idx <= '0;
         cnt      <= (IDX_W+1)'(1);
      end else if (state == SCAN) begin
         if (vec_buf[cnt[IDX_W-1:0]] > best) begin
            best     <= vec_buf[cnt[IDX_W-1:0]];
            best_idx <= cnt[IDX_W-1:0];
         end
         if (cnt != LAST_CNT) begin
            cnt <= cnt + (IDX_W+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_nn_argmax_stage.sv
// tb/tb_nn_argmax_stage.sv - randomized self-checking bench for nn_argmax_stage
module tb_nn_argmax_stage;
   import nn_argmax_stage_pkg::*;

   localparam int FEATURES = 11;
   localparam int IDX_W    = 4;

   logic             clk = 1'b0;
   logic             rst;
   nn_data_t         data [FEATURES];
   logic             data_v;
   logic             in_ready;
   logic [IDX_W-1:0] class_o;
   nn_data_t         max_o;
   logic             out_v;
   logic             out_ready;

   int errors = 0;
   int checks = 0;

   nn_argmax_stage #(.FEATURES(FEATURES), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_i    (data),
      .data_v    (data_v),
      .in_ready  (in_ready),
      .class_o   (class_o),
      .max_o     (max_o),
      .out_v     (out_v),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference: first index holding the largest signed value
   task automatic ref_argmax(output int idx, output nn_data_t mx);
      idx = 0;
      mx  = data[0];
      for (int i = 1; i < FEATURES; i++) begin
         if (data[i] > mx) begin
            mx  = data[i];
            idx = i;
         end
      end
   endtask

   // send the vector in data[], wait for the result, hold back-pressure for 'hold' cycles
   task automatic run_vector(input string tag, input int hold, input bit scramble);
      int       exp_idx;
      nn_data_t exp_max;
      int       lat;
      ref_argmax(exp_idx, exp_max);
      out_ready = (hold == 0);
      data_v    = 1'b1;
      lat = 0;
      while (!in_ready && lat < 50) begin
         step();
         lat++;
      end
      check({tag, "_in_ready"}, in_ready, 1'b1);
      step();
      data_v = 1'b0;
      if (scramble) begin
         for (int i = 0; i < FEATURES; i++) data[i] = -16'sd100;
         data[0] = 16'sh7FFF;
      end
      lat = 0;
      while (!out_v && lat < 200) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, FEATURES - 1);
      check({tag, "_class"}, class_o, exp_idx);
      check({tag, "_max"}, max_o, exp_max);
      for (int c = 0; c < hold; c++) begin
         if (c == 2) begin
            for (int i = 0; i < FEATURES; i++) data[i] = nn_data_t'($urandom);
            data_v = 1'b1;
         end else begin
            data_v = 1'b0;
         end
         step();
         check({tag, "_bp_out_v"}, out_v, 1'b1);
         check({tag, "_bp_in_ready"}, in_ready, 1'b0);
         check({tag, "_bp_class"}, class_o, exp_idx);
         check({tag, "_bp_max"}, max_o, exp_max);
      end
      data_v    = 1'b0;
      out_ready = 1'b1;
      step();
      check({tag, "_out_v_drop"}, out_v, 1'b0);
      check({tag, "_idle_in_ready"}, in_ready, 1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      data_v    = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < FEATURES; i++) data[i] = '0;
      step();
      step();
      rst = 1'b0;

      // reset then idle
      for (int c = 0; c < 20; c++) begin
         check("rst_in_ready", in_ready, 1'b1);
         check("rst_out_v", out_v, 1'b0);
         check("rst_class", class_o, 0);
         check("rst_max", max_o, 0);
         step();
      end

      // basic max
      for (int i = 0; i < FEATURES; i++) data[i] = nn_data_t'(i);
      data[5] = 16'sh0500;
      run_vector("basic", 0, 1'b0);
      check("basic_class_const", class_o, 5);
      check("basic_max_const", max_o, 16'h0500);

      // negatives with a tie at 3 and 7
      for (int i = 0; i < FEATURES; i++) data[i] = 16'shFF00;
      data[3] = 16'sh0080;
      data[7] = 16'sh0080;
      run_vector("tie", 0, 1'b0);
      check("tie_class_const", class_o, 3);

      // all equal
      for (int i = 0; i < FEATURES; i++) data[i] = 16'sh1234;
      run_vector("equal", 0, 1'b0);
      check("equal_class_const", class_o, 0);

      // back-pressure with an ignored data_v pulse
      for (int i = 0; i < FEATURES; i++) data[i] = nn_data_t'($urandom);
      run_vector("bp", 15, 1'b0);

      // reset mid-scan
      for (int i = 0; i < FEATURES; i++) data[i] = nn_data_t'(i * 3 - 20);
      out_ready = 1'b1;
      data_v    = 1'b1;
      step();
      data_v = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_class", class_o, 0);
      check("mid_rst_max", max_o, 0);
      check("mid_rst_in_ready", in_ready, 1'b1);
      for (int c = 0; c < 20; c++) begin
         check("mid_rst_out_v", out_v, 1'b0);
         step();
      end
      for (int i = 0; i < FEATURES; i++) data[i] = nn_data_t'(i);
      data[10] = 16'sh4000;
      run_vector("after_rst", 0, 1'b0);
      check("after_rst_class_const", class_o, 10);

      // input change after capture
      for (int i = 0; i < FEATURES; i++) data[i] = nn_data_t'(i * 16);
      data[6] = 16'sh0300;
      run_vector("isolate", 0, 1'b1);
      check("isolate_class_const", class_o, 6);

      // randomized vectors, half drawn from a narrow range to force ties
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < FEATURES; i++) begin
            if (n % 2 == 0) data[i] = nn_data_t'($urandom);
            else            data[i] = nn_data_t'(int'($urandom_range(0, 4)) - 2);
         end
         run_vector("rand", (n % 3 == 0) ? int'($urandom_range(1, 6)) : 0, n[2]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
